// File: rtl/vernam_pkg.sv
// Shared types and constants for the Vernam receive-side decipher engine.
// Holds the FSM state encoding, default widths and the weak-key constant.
package vernam_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Key byte value that leaves a plaintext byte unencrypted.
  localparam int unsigned ZERO_KEY = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_KEY,
    S_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/vernam_out_stage.sv
// Plaintext output stage: pt_q register plus valid/ready holding.
// Ports: load/ct/key in, ready in, pt_valid/pt_data/fire out.
module vernam_out_stage
  import vernam_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] ct,
  input  logic [DATA_W-1:0] key,
  input  logic              ready,
  output logic              pt_valid,
  output logic [DATA_W-1:0] pt_data,
  output logic              fire
);

  logic [DATA_W-1:0] pt_q;
  logic              valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pt_q    <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      pt_q    <= ct ^ key;
      valid_q <= 1'b1;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign fire     = valid_q & ready;
  assign pt_valid = valid_q;
  // Data bus reads zero whenever no byte is offered.
  assign pt_data  = valid_q ? pt_q : '0;

endmodule

// File: rtl/vernam_decipher.sv
// Vernam decipher: XORs ciphertext read from RAM with a key stream, byte by byte.
// Ports: start/base_addr/length job, mem_* RAM read, key_* and pt_* handshakes,
// busy/done status; key_err only with VERNAM_ZEROKEY_CHECK_EN defined.
module vernam_decipher
  import vernam_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              key_req,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  output logic              pt_valid,
  output logic [DATA_W-1:0] pt_data,
  input  logic              pt_ready
`ifdef VERNAM_ZEROKEY_CHECK_EN
  ,
  output logic              key_err
`endif
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] ct_q;
  logic              key_load;
  logic              fire;

  assign key_load = (state == S_KEY) && key_valid;

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = length;
          state_d = (length == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:    state_d = S_WAIT_MEM;
      S_WAIT_MEM: state_d = S_KEY;
      S_KEY: begin
        if (key_valid) state_d = S_OUT;
      end
      S_OUT: begin
        if (fire) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
          state_d = (rem_q == ADDR_W'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      ct_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      key_req  <= 1'b0;
    end else begin
      state    <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      if (state == S_WAIT_MEM) ct_q <= mem_rdata;
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_DONE);
      mem_en   <= (state_d == S_FETCH);
      mem_addr <= (state_d == S_FETCH) ? addr_d : '0;
      key_req  <= (state_d == S_KEY);
    end
  end

  vernam_out_stage #(
    .DATA_W(DATA_W)
  ) u_out (
    .clk     (clk),
    .reset   (reset),
    .load    (key_load),
    .ct      (ct_q),
    .key     (key_data),
    .ready   (pt_ready),
    .pt_valid(pt_valid),
    .pt_data (pt_data),
    .fire    (fire)
  );

`ifdef VERNAM_ZEROKEY_CHECK_EN
  // Sticky weak-key flag; a fresh job starts with a clean flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      key_err <= 1'b0;
    end else if (key_load && key_data == DATA_W'(ZERO_KEY)) begin
      key_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/vernam_decipher.md
# vernam_decipher

Receive-side Vernam engine: recovers plaintext from ciphertext stored in the block RAM by XOR-ing each stored byte with the matching byte of the shared key stream. Replaces the software XOR loop on the receiving PicoBlaze. It sits between the cipher RAM's read port, the key-stream source (the random-generator PicoBlaze's output register) and a downstream byte consumer. Processing is sequential: one byte at a time, in address order, with handshakes on both the key and plaintext sides.

## Interface
- ADDR_W, 8, RAM address width and length-counter width
- DATA_W, 8, byte width of ciphertext, key and plaintext
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first ciphertext address, captured on start
- length  in  ADDR_W  byte count, captured on start; 0 = empty job
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle pulse at job end
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  DATA_W  RAM data, valid one cycle after mem_en
- key_req  out  1  level request for the next key byte
- key_valid  in  1  key byte available; transfer when key_req & key_valid
- key_data  in  DATA_W  key byte
- pt_valid  out  1  plaintext byte valid
- pt_data  out  DATA_W  plaintext = ciphertext XOR key
- pt_ready  in  1  consumer accepts when pt_valid & pt_ready
- key_err  out  1  sticky weak-key flag (present only with VERNAM_ZEROKEY_CHECK_EN)

## Operation
- States: IDLE, FETCH, WAIT_MEM, KEY, OUT, DONE.
- IDLE: if start, capture base_addr into addr_q and length into remaining_q. If length==0, go to DONE; otherwise go to FETCH. Start while busy is ignored.
- FETCH: mem_en=1, mem_addr=addr_q; go to WAIT_MEM.
- WAIT_MEM: capture mem_rdata into ct_q; go to KEY.
- KEY: key_req=1. On key_valid, load pt_q = ct_q ^ key_data and go to OUT. Otherwise stay in KEY. The engine does not time out.
- OUT: pt_valid=1, pt_data=pt_q. On pt_ready: addr_q = addr_q+1 (wraps modulo 2^ADDR_W) and remaining_q decrements. If the decremented count is 0, go to DONE; otherwise go to FETCH.
- DONE: done=1 for one cycle, then IDLE.
- Outputs are driven only in their own state and are 0 elsewhere. pt_data holds its value while pt_valid is high.
- Key bytes are consumed strictly one per plaintext byte. No key byte is requested in IDLE, DONE or for an empty job.

## Timing
- Reset values: busy=0, done=0, mem_en=0, mem_addr=0, key_req=0, pt_valid=0, pt_data=0, key_err=0, state IDLE.
- Reset asserted mid-job aborts immediately. A held key or ciphertext byte is discarded and no done pulse is produced.
- With key_valid and pt_ready tied high, a byte takes 4 cycles (FETCH, WAIT_MEM, KEY, OUT). An N-byte job gives done N*4+1 cycles after the start cycle.
- Empty job: done asserts exactly 1 cycle after start, with no mem_en, key_req or pt_valid.
- A job starting at base_addr=0xFE with length=3 reads addresses FE, FF, 00.
- busy falls in the cycle after DONE, so start is accepted again the same cycle busy is low.

## Configuration
- VERNAM_ZEROKEY_CHECK_EN defined: key_err is set when a key byte equal to 0 is transferred. A zero key byte leaves that plaintext byte unencrypted. key_err stays set until reset or the next accepted start. The data path is unaffected.
- VERNAM_ZEROKEY_CHECK_EN undefined: the key_err port and its logic are absent.

## Structure
- Package vernam_pkg: state enum encoding, default ADDR_W/DATA_W constants, and the ZERO_KEY constant.
- One natural sub-module, vernam_out_stage: the pt_q register plus the valid/ready holding logic.
- The FSM, counters and RAM sequencing stay in the top module.

## Test plan
- Reset with all inputs high: every output reads 0 and no transition occurs until start.
- base_addr=0x10, length=2, RAM[0x10]=0x5A, RAM[0x11]=0xC3, keys 0xFF then 0x0F, ready always high -> pt_data 0xA5 then 0xCC, done at cycle 9.
- length=0 -> done one cycle after start; mem_en, key_req and pt_valid never rise.
- key_valid withheld 5 cycles, then pt_ready withheld 3 cycles -> key_req and pt_valid hold steady, pt_data stable, exactly one byte emitted.
- base_addr=0xFF, length=2 -> reads at 0xFF, then 0x00. Reset asserted during the second KEY state -> outputs 0, no done, and a new start is accepted after reset releases.
- With VERNAM_ZEROKEY_CHECK_EN, key 0x00 -> key_err=1 and pt_data equals the ciphertext. key_err clears on the next start.
